mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, sets address width for both requester ports and the memory port.
REQ-002 Parameter DATA_W, default 32, sets data width.
REQ-003 Parameter TIMEOUT, default 15, sets the maximum BUSY cycles before abort (legal range 1..255).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cpu_req  in  1  CPU (control FSM) transaction request, held until cpu_done.
REQ-007 cpu_we  in  1  CPU write enable (1 = write, 0 = read).
REQ-008 cpu_addr  in  ADDR_W  CPU byte address, stable while cpu_req is high.
REQ-009 cpu_wdata  in  DATA_W  CPU write data.
REQ-010 cpu_rdata  out  DATA_W  CPU read data, valid in the cpu_done cycle.
REQ-011 cpu_done  out  1  one-cycle CPU completion pulse.
REQ-012 cpu_stall  out  1  equals cpu_req AND NOT cpu_done; holds the control FSM in its current state.
REQ-013 ld_req, ld_we, ld_addr, ld_wdata, ld_rdata, ld_done  same directions, widths and meanings as the cpu_* ports, for the program loader/debug port.
REQ-014 mem_en  out  1  memory access strobe.
REQ-015 mem_we  out  1  memory write enable.
REQ-016 mem_addr  out  ADDR_W  memory address.
REQ-017 mem_wdata  out  DATA_W  memory write data.
REQ-018 mem_rdata  in  DATA_W  memory read data, valid when mem_ready is 1.
REQ-019 mem_ready  in  1  memory completion, sampled only while mem_en is 1.
REQ-020 err  out  1  sticky timeout flag; cleared only by reset.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-022 In IDLE with exactly one req high, the FSM SHALL latch that port's we/addr/wdata, record it as owner, and go to BUSY next cycle.
REQ-023 In IDLE with both reqs high, the FSM SHALL grant the port not granted last (round-robin); after reset, CPU has priority.
REQ-024 In BUSY, mem_en SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL be driven from the latched registers, not from live inputs.
REQ-025 In BUSY with mem_ready=1, the FSM SHALL capture mem_rdata into the owner's rdata register (reads only) and go to DONE.
REQ-026 In DONE, the owner's done SHALL be 1 for exactly one cycle, mem_en SHALL be 0, and the next state SHALL be IDLE.
REQ-027 A req still high in the IDLE cycle after DONE SHALL be treated as a new transaction.
REQ-028 Minimum latency SHALL be 3 cycles: req seen in IDLE (cycle N), BUSY at N+1, done at N+2 when mem_ready=1 at N+1.
REQ-029 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without mem_ready.
REQ-030 When the wait counter reaches TIMEOUT, the FSM SHALL go to DONE, set err, and leave the owner's rdata unchanged.
REQ-031 mem_ready=1 in the same cycle the counter reaches TIMEOUT SHALL count as success; err SHALL stay unchanged.
REQ-032 A non-owner's req changing during BUSY/DONE SHALL NOT affect the transaction in flight.
REQ-033 The owner dropping req mid-transaction SHALL NOT abort it; done still pulses.
REQ-034 rdata registers SHALL hold their value until the next successful read by the same port.

Reset
REQ-035 On rst_n=0, asynchronously: state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_done=0, ld_done=0, cpu_rdata=0, ld_rdata=0, err=0, wait counter=0, last-grant=loader (so CPU wins first).
REQ-036 Reset asserted mid-BUSY SHALL drop mem_en immediately and SHALL NOT pulse done after release.

Structure
REQ-037 The shared package mips_pkg SHALL hold the state encodings (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), the port IDs (PORT_CPU=0, PORT_LD=1), and the default widths.
REQ-038 Round-robin selection SHALL be the single sub-module rr_pick2 (inputs: two reqs plus last-grant; output: grant index and valid).

Verification
REQ-039 CPU read alone, addr=0x00000010, mem_ready at first BUSY cycle, mem_rdata=0x8C010004 -> cpu_done in cycle 3, cpu_rdata=0x8C010004, cpu_stall high in cycles 1-2 only.
REQ-040 Both reqs high in the same cycle after reset, repeated back-to-back -> grants alternate CPU, LD, CPU, LD, with no two consecutive grants to the same port.
REQ-041 LD write addr=0x40, wdata=0xDEADBEEF, mem_ready after 4 wait cycles -> mem_we=1 and mem_addr/mem_wdata stable for all 5 BUSY cycles; ld_done pulses once.
REQ-042 TIMEOUT=15, mem_ready never asserted -> DONE after 15 BUSY cycles, err=1, cpu_rdata unchanged; a following request completes normally with err still 1.
REQ-043 rst_n low during BUSY cycle 2 -> mem_en=0 in the same cycle, no done pulse after release, first post-reset grant goes to CPU.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the memory arbiter: FSM state codes, port ids
// and default bus widths.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: cpu_* and ld_* requester ports, mem_*
// memory port and err. slave = arbiter side, master = environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_stall;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_done;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_rdata, ld_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_rdata, ld_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  err
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. req0_i/req1_i requests, last_i last
// grant; gnt_o granted port id, valid_o any request present.
module rr_pick2
  import mips_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic gnt_o,
  output logic valid_o
);

  always_comb begin
    gnt_o   = PORT_CPU;
    valid_o = req0_i | req1_i;
    unique case (1'b1)
      (req0_i & req1_i):  gnt_o = ~last_i;
      (req1_i & ~req0_i): gnt_o = PORT_LD;
      default:            gnt_o = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and loader ports onto one memory port with timeout.
// Ports: clk, rst_n (async low), bus (mem_arbiter_if.slave).
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q,  last_d;
  logic              we_q,    we_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        cnt_q,   cnt_d;
  logic              err_q,   err_d;
  logic [DATA_W-1:0] crd_q,   crd_d;
  logic [DATA_W-1:0] lrd_q,   lrd_d;

  logic gnt;
  logic gvalid;
  logic busy;

  rr_pick2 u_rr (
    .req0_i  (bus.cpu_req),
    .req1_i  (bus.ld_req),
    .last_i  (last_q),
    .gnt_o   (gnt),
    .valid_o (gvalid)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    crd_d   = crd_q;
    lrd_d   = lrd_q;
    unique case (state_q)
      IDLE: begin
        if (gvalid) begin
          state_d = BUSY;
          owner_d = gnt;
          last_d  = gnt;
          cnt_d   = '0;
          if (gnt == PORT_LD) begin
            we_d    = bus.ld_we;
            addr_d  = bus.ld_addr;
            wdata_d = bus.ld_wdata;
          end else begin
            we_d    = bus.cpu_we;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
          end
        end
      end
      BUSY: begin
        // ready on the final allowed cycle still wins over timeout
        if (bus.mem_ready) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q == PORT_LD) lrd_d = bus.mem_rdata;
            else                    crd_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TO_LAST) begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= PORT_CPU;
      last_q  <= PORT_LD;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      crd_q   <= '0;
      lrd_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      crd_q   <= crd_d;
      lrd_q   <= lrd_d;
    end
  end

  assign busy          = (state_q == BUSY);
  assign bus.mem_en    = busy;
  assign bus.mem_we    = busy & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_done  = (state_q == DONE) && (owner_q == PORT_CPU);
  assign bus.ld_done   = (state_q == DONE) && (owner_q == PORT_LD);
  assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_done;
  assign bus.cpu_rdata = crd_q;
  assign bus.ld_rdata  = lrd_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed
// corner sequences and random transactions against a model.
module tb_mem_arbiter;
  import mips_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        creq, lreq, cwe, lwe;
    logic [31:0] caddr, laddr, cwd, lwd, mrd;
    int          waits;
    logic        g;
    logic [31:0] crd, lrd;
    logic        err;
  } txn_t;

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.ld_req    = 1'b0;
    bus.ld_we     = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_wdata  = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    drive_idle();
    tick();
    tick();
    chk1("rst mem_en", bus.mem_en, 1'b0);
    chk1("rst mem_we", bus.mem_we, 1'b0);
    chk32("rst mem_addr", bus.mem_addr, 32'h0);
    chk32("rst mem_wdata", bus.mem_wdata, 32'h0);
    chk1("rst cpu_done", bus.cpu_done, 1'b0);
    chk1("rst ld_done", bus.ld_done, 1'b0);
    chk32("rst cpu_rdata", bus.cpu_rdata, 32'h0);
    chk32("rst ld_rdata", bus.ld_rdata, 32'h0);
    chk1("rst err", bus.err, 1'b0);
    rst_n = 1'b1;
  endtask

  // One transaction from an IDLE cycle through DONE and back to IDLE.
  // Live inputs are scrambled during BUSY to prove the latched copy
  // drives memory and that the non-owner cannot disturb it.
  task automatic run(input txn_t t, input string tag);
    logic        owe;
    logic [31:0] oa, od;
    int          nb;
    owe = t.g ? t.lwe : t.cwe;
    oa  = t.g ? t.laddr : t.caddr;
    od  = t.g ? t.lwd : t.cwd;
    nb  = (t.waits < TO) ? t.waits + 1 : TO;
    bus.cpu_req   = t.creq;
    bus.cpu_we    = t.cwe;
    bus.cpu_addr  = t.caddr;
    bus.cpu_wdata = t.cwd;
    bus.ld_req    = t.lreq;
    bus.ld_we     = t.lwe;
    bus.ld_addr   = t.laddr;
    bus.ld_wdata  = t.lwd;
    bus.mem_ready = 1'b0;
    #1;
    chk1({tag, " idle_en"}, bus.mem_en, 1'b0);
    chk1({tag, " idle_stall"}, bus.cpu_stall, t.creq);
    tick();
    for (int i = 0; i < nb; i++) begin
      chk1({tag, " busy_en"}, bus.mem_en, 1'b1);
      chk1({tag, " busy_we"}, bus.mem_we, owe);
      chk32({tag, " busy_addr"}, bus.mem_addr, oa);
      chk32({tag, " busy_wdata"}, bus.mem_wdata, od);
      chk1({tag, " busy_done"}, bus.cpu_done | bus.ld_done, 1'b0);
      bus.cpu_req   = 1'($urandom);
      bus.ld_req    = 1'($urandom);
      bus.cpu_we    = 1'($urandom);
      bus.ld_we     = 1'($urandom);
      bus.cpu_addr  = $urandom;
      bus.ld_addr   = $urandom;
      bus.cpu_wdata = $urandom;
      bus.ld_wdata  = $urandom;
      bus.mem_ready = (i == t.waits);
      bus.mem_rdata = (i == t.waits) ? t.mrd : $urandom;
      tick();
    end
    bus.mem_ready = 1'b0;
    chk1({tag, " done_en"}, bus.mem_en, 1'b0);
    chk1({tag, " cpu_done"}, bus.cpu_done, ~t.g);
    chk1({tag, " ld_done"}, bus.ld_done, t.g);
    chk1({tag, " err"}, bus.err, t.err);
    chk32({tag, " cpu_rdata"}, bus.cpu_rdata, t.crd);
    chk32({tag, " ld_rdata"}, bus.ld_rdata, t.lrd);
    bus.cpu_req = 1'b0;
    bus.ld_req  = 1'b0;
    tick();
    chk1({tag, " post_done"}, bus.cpu_done | bus.ld_done, 1'b0);
    chk1({tag, " post_en"}, bus.mem_en, 1'b0);
  endtask

  txn_t tbl[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got[$];
    logic        m_last, m_err, g;
    logic [31:0] m_crd, m_lrd;
    txn_t        t;
    int          sel, r;

    //         creq lreq cwe lwe caddr laddr cwd lwd mrd waits g crd lrd err
    tbl[0]  = '{0, 1, 0, 1, 32'h0, 32'h40, 32'h0, 32'hDEADBEEF,
                32'h5A5A5A5A, 4, PORT_LD, 32'h0, 32'h0, 0};
    tbl[1]  = '{1, 0, 0, 0, 32'h100, 32'h0, 32'h0, 32'h0,
                32'h11111111, 0, PORT_CPU, 32'h11111111, 32'h0, 0};
    tbl[2]  = '{0, 1, 0, 0, 32'h0, 32'h200, 32'h0, 32'h0,
                32'h22222222, 2, PORT_LD, 32'h11111111, 32'h22222222, 0};
    tbl[3]  = '{1, 1, 0, 1, 32'h300, 32'h304, 32'h0, 32'h0BADF00D,
                32'h33333333, 1, PORT_CPU, 32'h33333333, 32'h22222222, 0};
    tbl[4]  = '{1, 1, 0, 1, 32'h300, 32'h304, 32'h0, 32'hCAFEF00D,
                32'h44444444, 0, PORT_LD, 32'h33333333, 32'h22222222, 0};
    tbl[5]  = '{1, 0, 1, 0, 32'h500, 32'h0, 32'h12345678, 32'h0,
                32'h55555555, 14, PORT_CPU, 32'h33333333, 32'h22222222, 0};
    tbl[6]  = '{0, 1, 0, 0, 32'h0, 32'h600, 32'h0, 32'h0,
                32'h66666666, 14, PORT_LD, 32'h33333333, 32'h66666666, 0};
    tbl[7]  = '{1, 1, 0, 0, 32'h700, 32'h704, 32'h0, 32'h0,
                32'h77777777, 3, PORT_CPU, 32'h77777777, 32'h66666666, 0};
    tbl[8]  = '{1, 0, 0, 0, 32'h800, 32'h0, 32'h0, 32'h0,
                32'h88888888, 0, PORT_CPU, 32'h88888888, 32'h66666666, 0};
    tbl[9]  = '{1, 1, 0, 0, 32'h900, 32'h904, 32'h0, 32'h0,
                32'h99999999, 0, PORT_LD, 32'h88888888, 32'h99999999, 0};
    tbl[10] = '{1, 0, 0, 0, 32'hA00, 32'h0, 32'h0, 32'h0,
                32'hEEEEEEEE, 15, PORT_CPU, 32'h88888888, 32'h99999999, 1};
    tbl[11] = '{0, 1, 0, 0, 32'h0, 32'hB00, 32'h0, 32'h0,
                32'hAAAAAAAA, 0, PORT_LD, 32'h88888888, 32'hAAAAAAAA, 1};

    // basic CPU read, cycle by cycle
    do_reset();
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h10;
    #1;
    chk1("rd c1 stall", bus.cpu_stall, 1'b1);
    chk1("rd c1 en", bus.mem_en, 1'b0);
    tick();
    chk1("rd c2 en", bus.mem_en, 1'b1);
    chk1("rd c2 we", bus.mem_we, 1'b0);
    chk32("rd c2 addr", bus.mem_addr, 32'h10);
    chk1("rd c2 stall", bus.cpu_stall, 1'b1);
    chk1("rd c2 done", bus.cpu_done, 1'b0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h8C010004;
    tick();
    chk1("rd c3 done", bus.cpu_done, 1'b1);
    chk32("rd c3 rdata", bus.cpu_rdata, 32'h8C010004);
    chk1("rd c3 stall", bus.cpu_stall, 1'b0);
    chk1("rd c3 en", bus.mem_en, 1'b0);
    bus.cpu_req   = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    chk1("rd c4 done", bus.cpu_done, 1'b0);
    chk1("rd c4 stall", bus.cpu_stall, 1'b0);
    chk32("rd c4 rdata", bus.cpu_rdata, 32'h8C010004);

    // back-to-back contention alternates grants
    do_reset();
    bus.cpu_req   = 1'b1;
    bus.ld_req    = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0;
    for (int c = 0; c < 30 && got.size() < 4; c++) begin
      tick();
      if (bus.cpu_done) got.push_back(0);
      if (bus.ld_done)  got.push_back(1);
    end
    chk32("rr count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size(); i++)
      chk32($sformatf("rr grant%0d", i), 32'(got[i]), 32'(i % 2));
    bus.cpu_req   = 1'b0;
    bus.ld_req    = 1'b0;
    bus.mem_ready = 1'b0;
    tick();

    // vector table
    do_reset();
    for (int i = 0; i < 12; i++)
      run(tbl[i], $sformatf("tbl%0d", i));

    // reset during the second BUSY cycle
    do_reset();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h20;
    tick();
    tick();
    chk1("rstbusy pre_en", bus.mem_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rstbusy en_now", bus.mem_en, 1'b0);
    bus.cpu_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk1("rstbusy no_done", bus.cpu_done | bus.ld_done, 1'b0);
      chk1("rstbusy idle_en", bus.mem_en, 1'b0);
    end
    t = '{1, 1, 0, 0, 32'h30, 32'h34, 32'h0, 32'h0,
          32'h0F0F0F0F, 0, PORT_CPU, 32'h0F0F0F0F, 32'h0, 0};
    run(t, "rstbusy first");

    // random traffic against the model
    do_reset();
    m_last = PORT_LD;
    m_err  = 1'b0;
    m_crd  = '0;
    m_lrd  = '0;
    for (int n = 0; n < 80; n++) begin
      sel     = $urandom_range(1, 3);
      t.creq  = sel[0];
      t.lreq  = sel[1];
      t.cwe   = 1'($urandom);
      t.lwe   = 1'($urandom);
      t.caddr = $urandom;
      t.laddr = $urandom;
      t.cwd   = $urandom;
      t.lwd   = $urandom;
      t.mrd   = $urandom;
      r       = $urandom_range(0, 9);
      t.waits = (r == 0) ? TO : (r == 1) ? TO - 1 : $urandom_range(0, 4);
      if (t.creq && t.lreq) g = ~m_last;
      else                  g = t.lreq ? PORT_LD : PORT_CPU;
      m_last = g;
      if (t.waits < TO) begin
        if (!(g ? t.lwe : t.cwe)) begin
          if (g == PORT_LD) m_lrd = t.mrd;
          else              m_crd = t.mrd;
        end
      end else begin
        m_err = 1'b1;
      end
      t.g   = g;
      t.crd = m_crd;
      t.lrd = m_lrd;
      t.err = m_err;
      run(t, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
